jt93cx6_eeprom: RTL and testbench

//  Parametrised 93Cx6 serial EEPROM emulator (93C46/56/66/86 by AW, x8/x16 by DW).

---
 rtl/jt93cx6_eeprom.sv | 197 +++++++++++++++++++
 tb/tb_jt93cx6_eeprom.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt93cx6_eeprom.sv
// 93Cx6 serial EEPROM emulator: any AW, x8/x16, ERAL/WRAL, timed ready/busy, host dump port.
// Optional feature macro: JT93CX6_SEQREAD_EN (READ keeps streaming addr+1 while scs stays high).
module jt93cx6_eeprom #(
  parameter int AW       = 6,
  parameter int DW       = 16,
  parameter int BUSY_CYC = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sclk,
  input  logic          sdi,
  output logic          sdo,
  input  logic          scs,
  input  logic [AW-1:0] dump_addr,
  input  logic [DW-1:0] dump_din,
  input  logic          dump_we,
  output logic [DW-1:0] dump_dout,
  output logic          dump_flag
);
  typedef enum logic [2:0] {S_IDLE, S_OP, S_ADDR, S_WRDATA, S_RDOUT, S_EXEC, S_SWEEP, S_BUSY} state_t;
  typedef enum logic [2:0] {C_WRITE, C_ERASE, C_ERAL, C_WRAL, C_EWEN, C_EWDS} cmd_t;
  localparam int CW = 8;
  localparam int BW = $clog2(BUSY_CYC) + 1;

  logic [DW-1:0] r_mem [2**AW];
  state_t        r_state;
  cmd_t          r_cmd;
  logic [2:0]    r_sclk_s;
  logic [1:0]    r_sdi_s, r_scs_s;
  logic [1:0]    r_op;
  logic [AW-1:0] r_addr, r_sweep;
  logic [DW-1:0] r_wdata, r_rsh, r_dout;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_busy;
  logic          r_sdo, r_flag, r_wen, r_load;
  logic          w_rise, w_scs, w_sdi, w_ser_we;
  logic [AW-1:0] w_addr_nx, w_ser_addr;

  assign w_rise     = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_scs      = r_scs_s[1];
  assign w_sdi      = r_sdi_s[1];
  assign w_addr_nx  = {r_addr[AW-2:0], w_sdi};
  assign w_ser_we   = (r_state == S_SWEEP) ||
                      (r_state == S_EXEC && !w_scs && r_wen && (r_cmd == C_WRITE || r_cmd == C_ERASE));
  assign w_ser_addr = (r_state == S_SWEEP) ? r_sweep : r_addr;
  assign sdo        = r_sdo;
  assign dump_dout  = r_dout;
  assign dump_flag  = r_flag;

  // Serial commit owns the clash address; a dump write elsewhere in the same clk still lands.
  always_ff @(posedge clk) begin
    if (dump_we && !(w_ser_we && w_ser_addr == dump_addr)) r_mem[dump_addr] <= dump_din;
    if (w_ser_we) r_mem[w_ser_addr] <= r_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s <= '0;
      r_sdi_s  <= '0;
      r_scs_s  <= '0;
      r_dout   <= '0;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], sclk};
      r_sdi_s  <= {r_sdi_s[0], sdi};
      r_scs_s  <= {r_scs_s[0], scs};
      r_dout   <= r_mem[dump_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cmd   <= C_EWDS;
      r_op    <= '0;
      r_addr  <= '0;
      r_sweep <= '0;
      r_wdata <= '0;
      r_rsh   <= '0;
      r_cnt   <= '0;
      r_busy  <= '0;
      r_sdo   <= 1'b1;
      r_flag  <= 1'b0;
      r_wen   <= 1'b0;
      r_load  <= 1'b0;
    end else begin
      if (dump_we) r_flag <= 1'b0;
      // Word fetch for READ lands one clk after the address settles, well before the next sclk rise.
      if (r_load) begin
        r_rsh  <= r_mem[r_addr];
        r_load <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          r_sdo <= 1'b1;
          if (w_rise && w_scs && w_sdi) begin
            r_state <= S_OP;
            r_cnt   <= '0;
          end
        end
        S_OP: begin
          if (!w_scs) r_state <= S_IDLE;
          else if (w_rise) begin
            r_op <= {r_op[0], w_sdi};
            if (r_cnt == CW'(1)) begin
              r_state <= S_ADDR;
              r_cnt   <= '0;
            end else r_cnt <= r_cnt + CW'(1);
          end
        end
        S_ADDR: begin
          if (!w_scs) r_state <= S_IDLE;
          else if (w_rise) begin
            r_addr <= w_addr_nx;
            r_cnt  <= r_cnt + CW'(1);
            if (r_cnt == CW'(AW - 1)) begin
              r_cnt <= '0;
              case (r_op)
                2'b10: begin r_state <= S_RDOUT; r_sdo <= 1'b0; r_load <= 1'b1; end
                2'b01: begin r_state <= S_WRDATA; r_cmd <= C_WRITE; end
                2'b11: begin r_state <= S_EXEC; r_cmd <= C_ERASE; r_wdata <= '1; end
                default: begin
                  case (w_addr_nx[AW-1 -: 2])
                    2'b11:   begin r_state <= S_EXEC; r_cmd <= C_EWEN; end
                    2'b00:   begin r_state <= S_EXEC; r_cmd <= C_EWDS; end
                    2'b10:   begin r_state <= S_EXEC; r_cmd <= C_ERAL; r_wdata <= '1; end
                    default: begin r_state <= S_WRDATA; r_cmd <= C_WRAL; end
                  endcase
                end
              endcase
            end
          end
        end
        S_WRDATA: begin
          if (!w_scs) r_state <= S_IDLE;
          else if (w_rise) begin
            r_wdata <= {r_wdata[DW-2:0], w_sdi};
            if (r_cnt == CW'(DW - 1)) begin
              r_state <= S_EXEC;
              r_cnt   <= '0;
            end else r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RDOUT: begin
          if (!w_scs) r_state <= S_IDLE;
          else if (w_rise) begin
            if (r_cnt == CW'(DW)) r_sdo <= 1'b0;
            else begin
              r_sdo <= r_rsh[DW-1];
              r_rsh <= {r_rsh[DW-2:0], 1'b0};
              if (r_cnt == CW'(DW - 1)) begin
`ifdef JT93CX6_SEQREAD_EN
                r_addr <= r_addr + AW'(1);
                r_load <= 1'b1;
                r_cnt  <= '0;
`else
                r_cnt  <= r_cnt + CW'(1);
`endif
              end else r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_EXEC: begin
          if (!w_scs) begin
            r_state <= S_IDLE;
            if (r_cmd == C_EWEN) r_wen <= 1'b1;
            else if (r_cmd == C_EWDS) r_wen <= 1'b0;
            else if (r_wen) begin
              r_flag <= 1'b1;
              r_sdo  <= 1'b0;
              if (r_cmd == C_ERAL || r_cmd == C_WRAL) begin
                r_state <= S_SWEEP;
                r_sweep <= '0;
              end else begin
                r_state <= S_BUSY;
                r_busy  <= BW'(BUSY_CYC - 1);
              end
            end
          end
        end
        S_SWEEP: begin
          r_sweep <= r_sweep + AW'(1);
          if (r_sweep == '1) begin
            r_state <= S_BUSY;
            r_busy  <= BW'(BUSY_CYC - 1);
          end
        end
        S_BUSY: begin
          if (r_busy == '0) begin
            r_state <= S_IDLE;
            r_sdo   <= 1'b1;
          end else r_busy <= r_busy - BW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jt93cx6_eeprom.sv
// Randomised bench for jt93cx6_eeprom (AW=6, DW=16, BUSY_CYC=128) against a word-array model.
module tb_jt93cx6_eeprom;
  logic        clk = 1'b0;
  logic        rst_n, sclk, sdi, scs, dump_we;
  logic [5:0]  dump_addr;
  logic [15:0] dump_din;
  logic        sdo, dump_flag;
  logic [15:0] dump_dout;

  logic [15:0] m_mem [64];
  bit          m_wen, m_flag;
  int          n_tests = 0, n_fail = 0;

  jt93cx6_eeprom #(.AW(6), .DW(16), .BUSY_CYC(128)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .sdi(sdi), .sdo(sdo), .scs(scs),
    .dump_addr(dump_addr), .dump_din(dump_din), .dump_we(dump_we),
    .dump_dout(dump_dout), .dump_flag(dump_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic bit_io(input logic b, output logic o);
    @(negedge clk); sdi = b;
    repeat (4) @(negedge clk); sclk = 1'b1;
    repeat (4) @(negedge clk); o = sdo; sclk = 1'b0;
  endtask

  task automatic cs_on;
    @(negedge clk); scs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic cs_off;
    @(negedge clk); scs = 1'b0; sdi = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [5:0] a, input logic [15:0] d, input int nd);
    logic o;
    cs_on;
    bit_io(1'b1, o); bit_io(op[1], o); bit_io(op[0], o);
    for (int i = 5; i >= 0; i--) bit_io(a[i], o);
    for (int i = 0; i < nd; i++) bit_io(d[15-i], o);
  endtask

  // Drops scs, re-raises it, counts clk samples with sdo low until ready returns.
  task automatic commit_measure(input int limit, output int n);
    bit done;
    done = 0; n = 0;
    @(negedge clk); scs = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (i == 5) scs = 1'b1;
      if (sdo === 1'b0) n++;
      else if (n > 0) done = 1;
    end
    cs_off;
  endtask

  task automatic dump_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk); dump_addr = a; dump_din = d; dump_we = 1'b1;
    @(negedge clk); dump_we = 1'b0;
    m_mem[a] = d; m_flag = 0;
  endtask

  task automatic dump_rd(input logic [5:0] a, output logic [15:0] d);
    @(negedge clk); dump_addr = a;
    @(negedge clk); d = dump_dout;
  endtask

  task automatic check_word(input string nm, input logic [5:0] a);
    logic [15:0] d;
    dump_rd(a, d);
    n_tests++;
    if (d !== m_mem[a]) begin n_fail++; $display("FAIL %s addr %0d got %h exp %h", nm, a, d, m_mem[a]); end
  endtask

  task automatic check_flag(input string nm);
    n_tests++;
    if (dump_flag !== m_flag) begin n_fail++; $display("FAIL %s flag got %b exp %b", nm, dump_flag, m_flag); end
  endtask

  task automatic check_busy(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin n_fail++; $display("FAIL %s busy got %0d exp %0d", nm, got, exp); end
  endtask

  task automatic set_wen(input bit en);
    send_cmd(2'b00, en ? 6'b110000 : 6'b000000, 16'h0, 0);
    cs_off;
    m_wen = en;
  endtask

  task automatic do_read(input logic [5:0] a, input int nw);
    logic o;
    logic [15:0] got, exp;
    cs_on;
    bit_io(1'b1, o); bit_io(1'b1, o); bit_io(1'b0, o);
    for (int i = 5; i >= 0; i--) bit_io(a[i], o);
    n_tests++;
    if (o !== 1'b0) begin n_fail++; $display("FAIL read_dummy addr %0d got %b exp 0", a, o); end
    for (int w = 0; w < nw; w++) begin
      got = '0;
      for (int b = 0; b < 16; b++) begin bit_io(1'b0, o); got = {got[14:0], o}; end
`ifdef JT93CX6_SEQREAD_EN
      exp = m_mem[6'(a + w)];
`else
      exp = (w == 0) ? m_mem[a] : 16'h0000;
`endif
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL read_word addr %0d word %0d got %h exp %h", a, w, got, exp); end
    end
    cs_off;
  endtask

  task automatic preload;
    for (int a = 0; a < 64; a++) dump_write(6'(a), 16'($urandom_range(0, 16'hFFFE)));
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sclk = 1'b0; sdi = 1'b0; scs = 1'b0;
    dump_we = 1'b0; dump_addr = '0; dump_din = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (sdo !== 1'b1) begin n_fail++; $display("FAIL reset_sdo got %b exp 1", sdo); end
    n_tests++; if (dump_dout !== 16'h0) begin n_fail++; $display("FAIL reset_dout got %h exp 0000", dump_dout); end
    n_tests++; if (dump_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag got %b exp 0", dump_flag); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    m_wen = 0; m_flag = 0;
  endtask

  task automatic test_read;
    dump_write(6'd5, 16'hA55A);
    do_read(6'd5, 1);
    for (int i = 0; i < 4; i++) do_read(6'($urandom_range(0, 63)), 1);
  endtask

  task automatic test_write_disabled;
    int n;
    set_wen(0);
    send_cmd(2'b01, 6'd3, 16'h1234, 16);
    commit_measure(200, n);
    check_busy("wr_disabled", n, 0);
    check_word("wr_disabled_mem", 6'd3);
    check_flag("wr_disabled");
  endtask

  task automatic test_write_enabled;
    int n;
    set_wen(1);
    send_cmd(2'b01, 6'd3, 16'h1234, 16);
    commit_measure(400, n);
    m_mem[3] = 16'h1234; m_flag = 1;
    check_busy("wr_enabled", n, 128);
    check_word("wr_enabled_mem", 6'd3);
    check_flag("wr_enabled");
    dump_write(6'd10, 16'($urandom));
    check_flag("dump_we_clears");
  endtask

  task automatic test_random_ops;
    int n;
    logic [5:0] a;
    logic [15:0] d;
    bit en, erase;
    for (int it = 0; it < 8; it++) begin
      en = 1'($urandom_range(0, 1)); erase = 1'($urandom_range(0, 1));
      a = 6'($urandom_range(0, 63)); d = 16'($urandom);
      set_wen(en);
      if (erase) send_cmd(2'b11, a, 16'h0, 0);
      else send_cmd(2'b01, a, d, 16);
      commit_measure(400, n);
      if (m_wen) begin m_mem[a] = erase ? 16'hFFFF : d; m_flag = 1; end
      check_busy("rand_op", n, m_wen ? 128 : 0);
      check_word("rand_op_mem", a);
      check_flag("rand_op");
    end
  endtask

  task automatic test_eral_wral;
    int n;
    set_wen(1);
    send_cmd(2'b00, 6'b100000, 16'h0, 0);
    commit_measure(600, n);
    for (int a = 0; a < 64; a++) m_mem[a] = 16'hFFFF;
    m_flag = 1;
    check_busy("eral", n, 64 + 128);
    for (int a = 0; a < 64; a++) check_word("eral_mem", 6'(a));
    check_flag("eral");
    send_cmd(2'b00, 6'b010000, 16'h00C3, 16);
    commit_measure(600, n);
    for (int a = 0; a < 64; a++) m_mem[a] = 16'h00C3;
    check_busy("wral", n, 64 + 128);
    for (int a = 0; a < 64; a++) check_word("wral_mem", 6'(a));
  endtask

  task automatic test_abort;
    int n;
    logic o;
    logic [5:0] a;
    set_wen(1);
    a = 6'($urandom_range(0, 63));
    send_cmd(2'b01, a, 16'($urandom), 10);
    commit_measure(100, n);
    check_busy("abort_wr", n, 0);
    check_word("abort_wr_mem", a);
    do_read(6'($urandom_range(0, 63)), 1);
    // A cut-short EWDS must leave the write enable latch set.
    cs_on;
    bit_io(1'b1, o); bit_io(1'b0, o); bit_io(1'b0, o); bit_io(1'b0, o); bit_io(1'b0, o);
    cs_off;
    send_cmd(2'b01, a, 16'h5AA5, 16);
    commit_measure(400, n);
    m_mem[a] = 16'h5AA5; m_flag = 1;
    check_busy("abort_ewds", n, 128);
    check_word("abort_ewds_mem", a);
  endtask

  task automatic clash_once(input logic [5:0] sa, input logic [5:0] da);
    logic [15:0] ds, dd;
    ds = 16'($urandom); dd = 16'($urandom);
    send_cmd(2'b01, sa, ds, 16);
    @(negedge clk); scs = 1'b0;
    repeat (2) @(negedge clk);
    dump_addr = da; dump_din = dd; dump_we = 1'b1;
    @(negedge clk); dump_we = 1'b0;
    for (int i = 0; i < 400 && sdo !== 1'b1; i++) @(negedge clk);
    n_tests++;
    if (sdo !== 1'b1) begin n_fail++; $display("FAIL clash_busy_end got %b exp 1", sdo); end
    m_mem[da] = dd;
    m_mem[sa] = ds;
    check_word("clash_serial", sa);
    if (da != sa) check_word("clash_dump", da);
  endtask

  task automatic test_dump_clash;
    logic [5:0] a;
    set_wen(1);
    a = 6'($urandom_range(0, 63));
    clash_once(a, a);
    clash_once(a, a + 6'd7);
  endtask

  task automatic test_seq_read;
    do_read(6'd63, 3);
  endtask

  task automatic test_reset_sweep;
    logic [15:0] d;
    int k, err;
    set_wen(1);
    preload;
    send_cmd(2'b00, 6'b100000, 16'h0, 0);
    @(negedge clk); scs = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if (sdo !== 1'b1) begin n_fail++; $display("FAIL rst_sweep_sdo got %b exp 1", sdo); end
    m_flag = 0; m_wen = 0;
    check_flag("rst_sweep");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    k = 64; err = 0;
    for (int a = 0; a < 64; a++) begin
      dump_rd(6'(a), d);
      if (k == 64 && d !== 16'hFFFF) k = a;
      if (k != 64 && d !== m_mem[a]) err++;
    end
    n_tests++; if (k == 0) begin n_fail++; $display("FAIL rst_sweep_first got %0d erased words exp >0", k); end
    n_tests++; if (k == 64) begin n_fail++; $display("FAIL rst_sweep_stop got %0d erased words exp <64", k); end
    n_tests++; if (err != 0) begin n_fail++; $display("FAIL rst_sweep_tail got %0d bad words exp 0", err); end
  endtask

  initial begin
    test_reset;
    preload;
    test_read;
    test_write_disabled;
    test_write_enabled;
    test_random_ops;
    test_eral_wral;
    test_abort;
    test_dump_clash;
    test_seq_read;
    test_reset_sweep;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
